// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: EX/MEM control and data inputs plus MEM/WB outputs of the
// memory-access stage, grouped so the pipeline and the stage share one bundle.
interface mem_access_unit_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int WRITE_REG_WIDTH  = 5,
    parameter int TEST_VALUE_WIDTH = 16
);
    // EX/MEM side
    logic                        RegWriteM;
    logic                        MemtoRegM;
    logic                        MemWriteM;
    logic [1:0]                  SizeM;
    logic                        SignedM;
    logic [DATA_WIDTH-1:0]       ALUOutM;
    logic [DATA_WIDTH-1:0]       WriteDataM;
    logic [WRITE_REG_WIDTH-1:0]  WriteRegM;
    logic                        StallM;
    logic                        MisalignM;
    logic [TEST_VALUE_WIDTH-1:0] Test_Value_M;

    // MEM/WB side
    logic                        RegWriteW;
    logic                        MemtoRegW;
    logic [DATA_WIDTH-1:0]       ReadDataW;
    logic [DATA_WIDTH-1:0]       ALUOutW;
    logic [WRITE_REG_WIDTH-1:0]  WriteRegW;

    // Pipeline side: drives the M inputs, observes stall and W registers
    modport master (
        output RegWriteM, MemtoRegM, MemWriteM, SizeM, SignedM,
               ALUOutM, WriteDataM, WriteRegM,
        input  StallM, MisalignM, Test_Value_M,
               RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW
    );

    // Memory-access stage side
    modport slave (
        input  RegWriteM, MemtoRegM, MemWriteM, SizeM, SignedM,
               ALUOutM, WriteDataM, WriteRegM,
        output StallM, MisalignM, Test_Value_M,
               RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: pipeline MEM stage with a word-organised data memory, a
// configurable load latency (1..4 cycles, stalling upstream while a load is in
// flight) and the MEM/WB pipeline register.
// Optional feature macro: MEM_ACCESS_SUBWORD_EN enables byte/halfword access
// and sign extension; without it every access is a full word.
module mem_access_unit #(
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH            = 256,  // power of two: index is a plain bit slice
    parameter int WRITE_REG_WIDTH  = 5,
    parameter int TEST_VALUE_WIDTH = 16,
    parameter int MEM_LATENCY      = 1     // 1..4
) (
    input logic              CLK,
    input logic              RST,
    mem_access_unit_if.slave bus
);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [1:0] CNT_LAST = 2'(MEM_LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic                       misalign_q, misalign_d;
    logic                       regwrite_q, regwrite_d;
    logic                       memtoreg_q, memtoreg_d;
    logic [DATA_WIDTH-1:0]      readdata_q, readdata_d;
    logic [DATA_WIDTH-1:0]      aluout_q, aluout_d;
    logic [WRITE_REG_WIDTH-1:0] writereg_q, writereg_d;
    logic [DATA_WIDTH-1:0]      mem_q [DEPTH];

    logic [IDX_W-1:0]      idx;
    logic [1:0]            lane;
    logic                  is_load, is_mem, misaligned, stall, store_en;
    logic [DATA_WIDTH-1:0] rdata, ld_data, wmask, wdata;

    assign idx     = bus.ALUOutM[IDX_W+1:2];
    assign lane    = bus.ALUOutM[1:0];
    assign is_mem  = bus.MemWriteM | bus.MemtoRegM;
    assign is_load = bus.MemtoRegM & ~bus.MemWriteM;   // store wins when both set
    assign rdata   = mem_q[idx];

`ifdef MEM_ACCESS_SUBWORD_EN
    logic [DATA_WIDTH-1:0] rshift;

    // Sub-word alignment check, lane write mask and right-justified load data
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        misaligned = 1'b0;
        wmask      = '1;
        wdata      = bus.WriteDataM;
        rshift     = rdata >> {lane, 3'b000};
        ld_data    = rshift;
        case (bus.SizeM)
            2'b00: begin
                wmask   = DATA_WIDTH'(8'hFF) << {lane, 3'b000};
                wdata   = DATA_WIDTH'(bus.WriteDataM[7:0]) << {lane, 3'b000};
                ld_data = {{(DATA_WIDTH-8){bus.SignedM & rshift[7]}}, rshift[7:0]};
            end
            2'b01: begin
                misaligned = lane[0];
                wmask      = DATA_WIDTH'(16'hFFFF) << {lane[1], 4'b0000};
                wdata      = DATA_WIDTH'(bus.WriteDataM[15:0]) << {lane[1], 4'b0000};
                ld_data    = {{(DATA_WIDTH-16){bus.SignedM & rshift[15]}}, rshift[15:0]};
            end
            default: misaligned = (lane != 2'b00);
        endcase
        misaligned = misaligned & is_mem;
    end
`else
    logic unused_subword;

    assign unused_subword = ^{bus.SizeM, bus.SignedM};
    assign misaligned     = is_mem & (lane != 2'b00);
    assign wmask          = '1;
    assign wdata          = bus.WriteDataM;
    assign ld_data        = rdata;
`endif

    assign store_en = bus.MemWriteM & ~misaligned & (state_q == IDLE);

    // Load sequencing, stall generation and MEM/WB next-state selection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall      = 1'b0;
        misalign_d = 1'b0;
        regwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        readdata_d = '0;
        aluout_d   = '0;
        writereg_d = '0;
        case (state_q)
            IDLE: begin
                if (misaligned) begin
                    misalign_d = 1'b1;              // bubble to W
                end else if (is_load && MEM_LATENCY > 1) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    cnt_d   = 2'd1;
                end else begin
                    regwrite_d = bus.RegWriteM & ~(bus.MemWriteM & bus.MemtoRegM);
                    memtoreg_d = is_load;
                    readdata_d = is_load ? ld_data : '0;
                    aluout_d   = bus.ALUOutM;
                    writereg_d = bus.WriteRegM;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    regwrite_d = bus.RegWriteM;
                    memtoreg_d = 1'b1;
                    readdata_d = ld_data;
                    aluout_d   = bus.ALUOutM;
                    writereg_d = bus.WriteRegM;
                    state_d    = IDLE;
                    cnt_d      = 2'd0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, latency counter, misalign pulse and MEM/WB register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            misalign_q <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            readdata_q <= '0;
            aluout_q   <= '0;
            writereg_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            readdata_q <= readdata_d;
            aluout_q   <= aluout_d;
            writereg_q <= writereg_d;
        end
    end

    // Data memory: lane-masked store on the accept edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the memory must read as zero after reset, so it is built from
            // resettable flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (store_en) begin
            mem_q[idx] <= (mem_q[idx] & ~wmask) | (wdata & wmask);
        end
    end

    // Stall is held low while reset is applied, even with a load on the inputs
    assign bus.StallM       = stall & ~RST;
    assign bus.MisalignM    = misalign_q;
    assign bus.RegWriteW    = regwrite_q;
    assign bus.MemtoRegW    = memtoreg_q;
    assign bus.ReadDataW    = readdata_q;
    assign bus.ALUOutW      = aluout_q;
    assign bus.WriteRegW    = writereg_q;
    assign bus.Test_Value_M = mem_q[0][TEST_VALUE_WIDTH-1:0];
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives identical stimulus into a latency-1 and a
// latency-3 instance and compares both against a byte-addressed memory model.
module tb_mem_access_unit;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int WRW   = 5;
    localparam int TVW   = 16;
`ifdef MEM_ACCESS_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           reg_write_m = 1'b0, mem_to_reg_m = 1'b0, mem_write_m = 1'b0;
    logic           signed_m = 1'b0;
    logic [1:0]     size_m = 2'b00;
    logic [DW-1:0]  alu_out_m = '0, write_data_m = '0;
    logic [WRW-1:0] write_reg_m = '0;

    mem_access_unit_if #(.DATA_WIDTH(DW), .WRITE_REG_WIDTH(WRW), .TEST_VALUE_WIDTH(TVW)) bus1 ();
    mem_access_unit_if #(.DATA_WIDTH(DW), .WRITE_REG_WIDTH(WRW), .TEST_VALUE_WIDTH(TVW)) bus3 ();

    assign bus1.RegWriteM  = reg_write_m;   assign bus3.RegWriteM  = reg_write_m;
    assign bus1.MemtoRegM  = mem_to_reg_m;  assign bus3.MemtoRegM  = mem_to_reg_m;
    assign bus1.MemWriteM  = mem_write_m;   assign bus3.MemWriteM  = mem_write_m;
    assign bus1.SizeM      = size_m;        assign bus3.SizeM      = size_m;
    assign bus1.SignedM    = signed_m;      assign bus3.SignedM    = signed_m;
    assign bus1.ALUOutM    = alu_out_m;     assign bus3.ALUOutM    = alu_out_m;
    assign bus1.WriteDataM = write_data_m;  assign bus3.WriteDataM = write_data_m;
    assign bus1.WriteRegM  = write_reg_m;   assign bus3.WriteRegM  = write_reg_m;

    mem_access_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .WRITE_REG_WIDTH(WRW),
                      .TEST_VALUE_WIDTH(TVW), .MEM_LATENCY(1))
        dut1 (.CLK(clk), .RST(rst), .bus(bus1));
    mem_access_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .WRITE_REG_WIDTH(WRW),
                      .TEST_VALUE_WIDTH(TVW), .MEM_LATENCY(3))
        dut3 (.CLK(clk), .RST(rst), .bus(bus3));

    // Reference memory: little-endian byte array, wrapping at DEPTH words
    logic [7:0] mem_b [DEPTH*4];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic mw, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] wreg);
        reg_write_m  = rw;
        mem_to_reg_m = m2r;
        mem_write_m  = mw;
        size_m       = sz;
        signed_m     = sg;
        alu_out_m    = addr;
        write_data_m = wdata;
        write_reg_m  = wreg;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH*4; i++) mem_b[i] = 8'h00;
    endtask

    // Issue one operation (called just after a rising edge), follow it to
    // completion on both instances and check every observable against the model.
    task automatic run_op(input logic rw, input logic m2r, input logic mw, input logic [1:0] sz,
                          input logic sg, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] wreg);
        int          nb, base, edges;
        logic        ld, mis, e_rw, e_m2r;
        logic [31:0] val, e_rd, e_alu;
        logic [4:0]  e_wr;
        ld   = m2r & ~mw;
        nb   = !SUBWORD ? 4 : (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis  = (mw | m2r) && ((addr % 32'(nb)) != 32'd0);
        base = int'(addr % 32'(DEPTH*4));
        val  = '0;
        if (!mis) begin
            for (int i = 0; i < nb; i++) val = val | (32'(mem_b[base+i]) << (8*i));
            if (SUBWORD && sg && nb < 4 && val[8*nb-1]) val = val | ~((32'd1 << (8*nb)) - 32'd1);
        end
        e_rw  = !mis & rw & ~(mw & m2r);
        e_m2r = !mis & ld;
        e_rd  = (!mis && ld) ? val : 32'd0;
        e_alu = mis ? 32'd0 : addr;
        e_wr  = mis ? 5'd0 : wreg;
        edges = (ld && !mis) ? 3 : 1;

        drive(rw, m2r, mw, sz, sg, addr, wdata, wreg);
        for (int k = 0; k < edges; k++) begin
            @(negedge clk);
            check("stall_l1", bus1.StallM, 1'b0);
            check("stall_l3", bus3.StallM, (k < edges - 1));
            if (k > 0) begin
                check("bubble_l3_ctl", {bus3.RegWriteW, bus3.MemtoRegW, bus3.WriteRegW}, 0);
                check("bubble_l3_data", {bus3.ReadDataW, bus3.ALUOutW}, 0);
                check("hold_l1_rd", bus1.ReadDataW, e_rd);
            end
            @(posedge clk);
            #1;
        end
        if (mw && !mis) begin
            for (int i = 0; i < nb; i++) mem_b[base+i] = wdata[8*i +: 8];
        end

        check("w_l1_ctl", {bus1.RegWriteW, bus1.MemtoRegW, bus1.WriteRegW}, {e_rw, e_m2r, e_wr});
        check("w_l1_rd", bus1.ReadDataW, e_rd);
        check("w_l1_alu", bus1.ALUOutW, e_alu);
        check("w_l3_ctl", {bus3.RegWriteW, bus3.MemtoRegW, bus3.WriteRegW}, {e_rw, e_m2r, e_wr});
        check("w_l3_rd", bus3.ReadDataW, e_rd);
        check("w_l3_alu", bus3.ALUOutW, e_alu);
        check("misalign_l1", bus1.MisalignM, mis);
        check("misalign_l3", bus3.MisalignM, mis);
        check("testval_l1", bus1.Test_Value_M, {mem_b[1], mem_b[0]});
        check("testval_l3", bus3.Test_Value_M, {mem_b[1], mem_b[0]});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  kind;
        logic [31:0] addr;
        clear_model();

        // Reset state
        #12;
        check("rst_w_l1", {bus1.RegWriteW, bus1.MemtoRegW, bus1.WriteRegW, bus1.MisalignM}, 0);
        check("rst_w_l3", {bus3.ReadDataW, bus3.ALUOutW}, 0);
        check("rst_stall", {bus1.StallM, bus3.StallM}, 0);
        check("rst_testval", bus3.Test_Value_M, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Word store then load at 0x10
        run_op(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
        run_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd7);
        check("ld_word_l1", bus1.ReadDataW, 32'hDEADBEEF);
        check("ld_word_l3", bus3.ReadDataW, 32'hDEADBEEF);

`ifdef MEM_ACCESS_SUBWORD_EN
        // Sub-word loads and stores
        run_op(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 5'd3);
        check("ld_byte_signed", bus1.ReadDataW, 32'hFFFFFFDE);
        run_op(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 5'd3);
        check("ld_byte_unsigned", bus3.ReadDataW, 32'h000000DE);
        run_op(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 5'd0);
        run_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd4);
        check("ld_after_half", bus1.ReadDataW, 32'h1234BEEF);
        run_op(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 5'd4);
        check("half_odd_misalign", bus1.MisalignM, 1'b1);
`endif

        // Misaligned word store leaves memory untouched
        run_op(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h11111111, 5'd0);
        run_op(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h6, 32'hCAFEF00D, 5'd0);
        check("misalign_pulse", bus3.MisalignM, 1'b1);
        run_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 5'd9);
        check("misalign_unchanged", bus1.ReadDataW, 32'h11111111);

        // Word 0 visible on the debug port right after the store edge
        run_op(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0000ABCD, 5'd0);
        check("testval_abcd", bus1.Test_Value_M, 16'hABCD);

        // Store and load flags together: store only, no register write
        run_op(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h55AA55AA, 5'd12);
        check("store_load_rw", bus3.RegWriteW, 1'b0);

        // Randomized mix
        for (int n = 0; n < 200; n++) begin
            kind = 2'($urandom_range(0, 3));
            addr = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h7F);
            run_op(1'($urandom), kind[1], (kind == 2'd1) || (kind == 2'd3),
                   2'($urandom_range(0, 3)), 1'($urandom), addr, $urandom, 5'($urandom));
        end

        // Reset while the latency-3 instance is busy with a load
        run_op(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h89ABCDEF, 5'd0);
        run_op(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0000ABCD, 5'd0);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 5'd5);
        @(posedge clk);
        #1;
        check("busy_stall", bus3.StallM, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_busy_stall", bus3.StallM, 1'b0);
        check("rst_busy_rw", bus3.RegWriteW, 1'b0);
        check("rst_busy_testval", bus3.Test_Value_M, 0);
        clear_model();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 5'd5);
        check("rst_mem_zero", bus3.ReadDataW, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, data and address width.
REQ-002 SHALL have parameter DEPTH, 256, number of data-memory words.
REQ-003 SHALL have parameter WRITE_REG_WIDTH, 5, destination register index width.
REQ-004 SHALL have parameter TEST_VALUE_WIDTH, 16, debug observation width.
REQ-005 SHALL have parameter MEM_LATENCY, 1, load latency in cycles; legal range 1..4.
REQ-006 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-008 SHALL have ports RegWriteM, MemtoRegM, MemWriteM  input  1 each  control from EX/MEM; MemtoRegM=1 marks a load.
REQ-009 SHALL have ports SizeM  input  2  00 byte, 01 halfword, 10 word (11 treated as word); SignedM  input  1  sign-extend sub-word loads.
REQ-010 SHALL have ports ALUOutM  input  DATA_WIDTH  byte address or ALU result; WriteDataM  input  DATA_WIDTH  store data; WriteRegM  input  WRITE_REG_WIDTH  destination.
REQ-011 SHALL have port StallM  output  1  load in progress; upstream holds all M inputs stable while high.
REQ-012 SHALL have port MisalignM  output  1  registered, one-cycle pulse on misaligned access.
REQ-013 SHALL have MEM/WB register outputs RegWriteW, MemtoRegW (1), ReadDataW, ALUOutW (DATA_WIDTH), WriteRegW (WRITE_REG_WIDTH).
REQ-014 SHALL have port Test_Value_M  output  TEST_VALUE_WIDTH  combinational, bits [TEST_VALUE_WIDTH-1:0] of memory word 0.

Function
REQ-015 Word index SHALL be ALUOutM[..:2] modulo DEPTH; byte lane ALUOutM[1:0].
REQ-016 Store (MemWriteM=1): lanes selected by SizeM/ALUOutM[1:0] written at the accept-cycle edge; other lanes unchanged; StallM never asserted.
REQ-017 MemWriteM and MemtoRegM both 1: store only; RegWriteW forced 0.
REQ-018 Load byte/half data SHALL be right-justified, zero- or sign-extended per SignedM.
REQ-019 FSM states IDLE, BUSY; counter cnt of width 2.
REQ-020 MEM_LATENCY=1: load completes in accept cycle; W registers capture at next edge; no stall.
REQ-021 MEM_LATENCY=L>1: IDLE+load -> BUSY, cnt=1; BUSY increments cnt; at cnt=L-1, W capture and -> IDLE.
REQ-022 StallM = (IDLE & load & L>1) | (BUSY & cnt<L-1); total stall L-1 cycles per load.
REQ-023 While StallM=1, W registers SHALL load a bubble (RegWriteW=0, MemtoRegW=0, others 0).
REQ-024 Misaligned (half at odd address, word with ALUOutM[1:0]!=0): memory untouched, no stall, bubble to W, MisalignM=1 next cycle.
REQ-025 Non-memory op: ALUOutW/WriteRegW/RegWriteW pass through with one-cycle latency; ReadDataW=0.

Reset
REQ-026 RST=1 SHALL asynchronously clear all W outputs, MisalignM, cnt, all memory words to 0; state -> IDLE; StallM=0.
REQ-027 Reset during BUSY SHALL abandon the load with no write-back.

Configuration
REQ-028 Macro MEM_ACCESS_SUBWORD_EN defined: SizeM/SignedM honoured per REQ-016/018/024.
REQ-029 Macro undefined: SizeM/SignedM ignored; all accesses are word; misalignment checks ALUOutM[1:0] only.

Verification
REQ-030 Store word 0xDEADBEEF @0x10, load word @0x10, L=1 -> ReadDataW=0xDEADBEEF next cycle, StallM never high.
REQ-031 L=3, load @0x10 -> StallM high 2 cycles, bubble in W during stall, ReadDataW=0xDEADBEEF on 3rd edge.
REQ-032 SUBWORD_EN, mem 0xDEADBEEF, load byte @0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-033 Store half 0x1234 @0x12 over 0xDEADBEEF -> word reads 0x1234BEEF; store word @0x06 -> MisalignM pulse, memory unchanged.
REQ-034 Store 0x0000ABCD @0x0 -> Test_Value_M=0xABCD same cycle after edge; RST mid-BUSY -> StallM=0, RegWriteW=0, memory zeroed.
